// File: rtl/ram_read_streamer.sv
// Read-side burst sequencer for a 1R1W RAM: issues reads, captures the registered
// read data and streams it out through a 2-entry buffer on a valid/ready port.
module ram_read_streamer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   REM_ONE  = 1;

    state_t            state;
    logic [ADDR_W:0]   remaining;
    logic              inflight;
    logic [1:0]        count;
    logic [DATA_W-1:0] spare;
    logic              pop;
    logic              push;
    logic [2:0]        occ;
    logic [1:0]        countNext;

    // m_data is the buffer head; spare holds the second word when two are queued
    assign m_valid   = (count != 2'd0);
    assign pop       = m_valid & m_ready;
    assign push      = inflight;
    assign countNext = count + {1'b0, push} - {1'b0, pop};

    // Only read when the word, counted with everything already owed downstream, fits
    assign occ    = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign ram_en = (state == RUN) && (remaining != '0) && (occ <= 3'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_addr  <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            count     <= 2'd0;
            spare     <= '0;
            m_data    <= '0;
        end else begin
            done     <= 1'b0;
            inflight <= ram_en;
            count    <= countNext;

            case (count)
                2'd0: if (push) m_data <= ram_dout;
                2'd1: begin
                    if (push && pop) m_data <= ram_dout;
                    else if (push)   spare  <= ram_dout;
                end
                2'd2: if (pop) begin
                    m_data <= spare;
                    if (push) spare <= ram_dout;
                end
                default: ;
            endcase

            case (state)
                IDLE: if (start) begin
                    if (len != '0) begin
                        ram_addr  <= base_addr;
                        remaining <= len;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end else begin
                        done <= 1'b1;
                    end
                end
                RUN: if (ram_en) begin
                    ram_addr  <= ram_addr + ADDR_ONE;
                    remaining <= remaining - REM_ONE;
                    if (remaining == REM_ONE) state <= DRAIN;
                end
                // Finish in the same edge as the last handshake so done follows it directly
                DRAIN: if (countNext == 2'd0) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) assert (!(count == 2'd2 && push && !pop));
    end

endmodule

// File: tb/tb_ram_read_streamer.sv
// Directed bench for ram_read_streamer: RAM model returns word = address, a negedge
// monitor logs reads, handshakes, done and busy relative to the start cycle.
module tb_ram_read_streamer;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   len = '0;
    logic              busy, done, ram_en, m_valid;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dout = '0;
    logic              m_ready = 1'b1;
    logic [DATA_W-1:0] m_data;

    ram_read_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .ram_en(ram_en), .ram_addr(ram_addr),
        .ram_dout(ram_dout), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_en) ram_dout <= {6'd0, ram_addr};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int enCyc[$], enAddr[$], hsCyc[$], hsData[$], doneCyc[$];
    int busyCnt, busyFirst, busyLast, occViol, stabViol, outstanding, startCyc, rel, hs;
    bit prevStall, randomReady;
    logic [DATA_W-1:0] prevData;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Log everything relative to the start cycle; outstanding mirrors buffer + in-flight words
    always @(negedge clk) begin
        if (rst_n) begin
            rel = cyc - startCyc;
            hs  = int'(m_valid && m_ready);
            if (prevStall && (!m_valid || m_data !== prevData)) stabViol++;
            prevStall = m_valid && !m_ready;
            prevData  = m_data;
            if (ram_en) begin
                enCyc.push_back(rel);
                enAddr.push_back(int'(ram_addr));
                if (outstanding - hs > 1) occViol++;
            end
            if (hs != 0) begin
                hsCyc.push_back(rel);
                hsData.push_back(int'(m_data));
            end
            if (done) doneCyc.push_back(rel);
            if (busy) begin
                busyCnt++;
                if (busyFirst < 0) busyFirst = rel;
                busyLast = rel;
            end
            outstanding += int'(ram_en) - hs;
        end else begin
            outstanding = 0;
            prevStall   = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (randomReady) m_ready = 1'($urandom_range(0, 1));
    end

    task automatic clearLog();
        enCyc.delete(); enAddr.delete(); hsCyc.delete(); hsData.delete(); doneCyc.delete();
        busyCnt = 0; busyFirst = -1; busyLast = -1; occViol = 0; stabViol = 0;
    endtask

    task automatic applyStimulus(input int b, input int n);
        @(posedge clk);
        #1;
        clearLog();
        base_addr = ADDR_W'(b);
        len       = (ADDR_W+1)'(n);
        start     = 1'b1;
        startCyc  = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        for (int k = 0; k < budget && doneCyc.size() == 0; k++) @(posedge clk);
        if (doneCyc.size() == 0) checkOutput("done_timeout", 0, 1);
        repeat (3) @(posedge clk);
    endtask

    task automatic checkWords(input string tag, input int b, input int n);
        checkOutput({tag, "_reads"}, enAddr.size(), n);
        checkOutput({tag, "_words"}, hsData.size(), n);
        for (int i = 0; i < n && i < hsData.size() && i < enAddr.size(); i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), enAddr[i], (b + i) % 1024);
            checkOutput($sformatf("%s_data%0d", tag, i), hsData[i], (b + i) % 1024);
        end
        checkOutput({tag, "_occ"}, occViol, 0);
        checkOutput({tag, "_stable"}, stabViol, 0);
        checkOutput({tag, "_done_cnt"}, doneCyc.size(), 1);
    endtask

    task automatic runBasic(input string tag);
        applyStimulus(12'h010, 4);
        waitDone(50);
        checkWords(tag, 12'h010, 4);
        checkOutput({tag, "_en_first"}, enCyc.size() > 0 ? enCyc[0] : -1, 1);
        checkOutput({tag, "_en_last"}, enCyc.size() > 3 ? enCyc[3] : -1, 4);
        checkOutput({tag, "_hs_first"}, hsCyc.size() > 0 ? hsCyc[0] : -1, 3);
        checkOutput({tag, "_hs_last"}, hsCyc.size() > 3 ? hsCyc[3] : -1, 6);
        checkOutput({tag, "_done_cyc"}, doneCyc.size() > 0 ? doneCyc[0] : -1, 7);
        checkOutput({tag, "_busy_first"}, busyFirst, 1);
        checkOutput({tag, "_busy_last"}, busyLast, 6);
        checkOutput({tag, "_busy_cnt"}, busyCnt, 6);
    endtask

    initial begin
        clearLog();
        startCyc = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_ram_en", int'(ram_en), 0);
        checkOutput("rst_m_valid", int'(m_valid), 0);
        checkOutput("rst_ram_addr", int'(ram_addr), 0);
        checkOutput("rst_m_data", int'(m_data), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        runBasic("basic");

        // Backpressure: ready low from the start until 10 cycles after m_valid rises
        m_ready = 1'b0;
        applyStimulus(12'h040, 8);
        for (int k = 0; k < 20 && !m_valid; k++) @(negedge clk);
        checkOutput("bp_valid_seen", int'(m_valid), 1);
        repeat (10) @(posedge clk);
        #1;
        m_ready = 1'b1;
        waitDone(100);
        checkWords("bp", 12'h040, 8);
        checkOutput("bp_en1_cyc", enCyc.size() > 1 ? enCyc[1] : -1, 2);
        checkOutput("bp_en2_cyc", enCyc.size() > 2 ? enCyc[2] : -1, 13);

        randomReady = 1'b1;
        applyStimulus(12'h0C0, 64);
        waitDone(2000);
        randomReady = 1'b0;
        m_ready = 1'b1;
        repeat (5) @(posedge clk);
        checkWords("rand", 12'h0C0, 64);

        applyStimulus(12'h3FE, 4);
        waitDone(50);
        checkWords("wrap", 12'h3FE, 4);

        applyStimulus(12'h055, 0);
        repeat (4) @(negedge clk);
        checkOutput("len0_reads", enCyc.size(), 0);
        checkOutput("len0_busy", busyCnt, 0);
        checkOutput("len0_done_cnt", doneCyc.size(), 1);
        checkOutput("len0_done_cyc", doneCyc.size() > 0 ? doneCyc[0] : -1, 1);

        // A second start while busy must not alter or queue behind the first burst
        applyStimulus(12'h100, 4);
        @(posedge clk);
        #1;
        base_addr = 10'h200;
        len = 11'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(50);
        repeat (3) @(negedge clk);
        checkWords("ign", 12'h100, 4);
        checkOutput("ign_done_cyc", doneCyc.size() > 0 ? doneCyc[0] : -1, 7);
        checkOutput("ign_busy_after", int'(busy), 0);

        applyStimulus(12'h020, 16);
        for (int k = 0; k < 50 && hsData.size() < 3; k++) @(posedge clk);
        checkOutput("mid_words_seen", hsData.size(), 3);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("mid_m_valid", int'(m_valid), 0);
        checkOutput("mid_ram_en", int'(ram_en), 0);
        checkOutput("mid_busy", int'(busy), 0);
        checkOutput("mid_done", int'(done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        runBasic("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
